decode_lifo: RTL and testbench

DECODE_LIFO -- requirements
Module: decode_lifo

---
 rtl/decode_lifo.sv | 110 +++++++++++
 tb/tb_decode_lifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/decode_lifo.sv
// Ping-pong bit LIFO that turns reverse-ordered traceback bits into forward-order output blocks.
// Latency: a block's last-written bit appears on OutBit the cycle after the edge that completes the bank.
// Backpressure: InReady drops only when both banks are full; bits offered then are dropped and Overflow sticks.
module decode_lifo #(
  parameter int DEPTH  = 32,
  parameter int WD_CNT = 5
) (
  input  logic CLOCK,
  input  logic Reset,
  input  logic Clear,
  input  logic InValid,
  input  logic InBit,
  output logic InReady,
  output logic OutBit,
  output logic OutValid,
  input  logic OutReady,
  output logic Overflow
);

  localparam logic [WD_CNT-1:0] LP_LAST = WD_CNT'(DEPTH - 1);

  // Bank storage: data only, never reset; validity lives in r_full.
  logic [DEPTH-1:0] r_mem [2];

  // Control state: per-bank FULL flags, write/read bank pointers and bit counters.
  logic [1:0]        r_full;
  logic              r_wbank;
  logic              r_rbank;
  logic [WD_CNT-1:0] r_wcnt;
  logic [WD_CNT-1:0] r_rcnt;
  logic              r_overflow;

  logic              w_wr_en;
  logic              w_drop;
  logic              w_rd_en;
  logic              w_fill_done;
  logic              w_drain_done;
  logic [1:0]        w_full_nxt;

  assign InReady  = ~r_full[r_wbank];
  assign OutValid = r_full[r_rbank];
  assign OutBit   = r_mem[r_rbank][r_rcnt];
  assign Overflow = r_overflow;

  assign w_wr_en      = InValid & InReady;
  assign w_drop       = InValid & ~InReady;
  assign w_rd_en      = OutValid & OutReady;
  assign w_fill_done  = w_wr_en & (r_wcnt == LP_LAST);
  assign w_drain_done = w_rd_en & (r_rcnt == '0);

  // Next FULL flags: a fill and a drain on the same edge always hit different banks,
  // since a write needs its bank empty and a read needs its bank full.
  always_comb begin
    w_full_nxt = r_full;
    if (w_fill_done) begin
      w_full_nxt[r_wbank] = 1'b1;
    end
    if (w_drain_done) begin
      w_full_nxt[r_rbank] = 1'b0;
    end
  end

  // Control registers; Clear flushes everything and overrides any read or write this cycle.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      r_full     <= 2'b00;
      r_wbank    <= 1'b0;
      r_rbank    <= 1'b0;
      r_wcnt     <= '0;
      r_rcnt     <= LP_LAST;
      r_overflow <= 1'b0;
    end else if (Clear) begin
      r_full     <= 2'b00;
      r_wbank    <= 1'b0;
      r_rbank    <= 1'b0;
      r_wcnt     <= '0;
      r_rcnt     <= LP_LAST;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_en) begin
        if (w_fill_done) begin
          r_wbank <= ~r_wbank;
          r_wcnt  <= '0;
        end else begin
          r_wcnt  <= r_wcnt + WD_CNT'(1);
        end
      end
      if (w_rd_en) begin
        if (w_drain_done) begin
          r_rbank <= ~r_rbank;
          r_rcnt  <= LP_LAST;
        end else begin
          r_rcnt  <= r_rcnt - WD_CNT'(1);
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Bit store: incoming bit lands at the write counter position of the bank being filled.
  always_ff @(posedge CLOCK) begin
    if (w_wr_en && !Clear) begin
      r_mem[r_wbank][r_wcnt] <= InBit;
    end
  end

endmodule

// File: tb/tb_decode_lifo.sv
// Bench for decode_lifo with DEPTH=8: directed scenarios followed by random traffic.
// Expected output bits come from a block-level model (queue of completed, reversed blocks).
// A monitor compares OutBit against the scoreboard head whenever the DUT shows OutValid.
module tb_decode_lifo;

  localparam int DEPTH  = 8;
  localparam int WD_CNT = 3;

  logic CLOCK = 1'b0;
  logic Reset;
  logic Clear;
  logic InValid;
  logic InBit;
  logic InReady;
  logic OutBit;
  logic OutValid;
  logic OutReady;
  logic Overflow;

  int total = 0;
  int bad   = 0;

  // Model state: bits of the block being assembled, and the expected output stream.
  bit pq[$];
  bit exp_q[$];
  bit m_ready;
  bit m_valid;
  bit m_ovf;

  decode_lifo #(.DEPTH(DEPTH), .WD_CNT(WD_CNT)) dut (
    .CLOCK   (CLOCK),
    .Reset   (Reset),
    .Clear   (Clear),
    .InValid (InValid),
    .InBit   (InBit),
    .InReady (InReady),
    .OutBit  (OutBit),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .Overflow(Overflow)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_status();
    int nblk;
    nblk    = (exp_q.size() + DEPTH - 1) / DEPTH;
    m_ready = (nblk < 2);
    m_valid = (nblk > 0);
  endtask

  task automatic model_flush();
    pq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    model_status();
  endtask

  // Applies one clock edge's worth of behaviour at block level.
  task automatic model_edge();
    if (Clear) begin
      model_flush();
    end else begin
      if (InValid) begin
        if (m_ready) begin
          pq.push_back(InBit);
          if (pq.size() == DEPTH) begin
            for (int k = DEPTH - 1; k >= 0; k--) exp_q.push_back(pq[k]);
            pq.delete();
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
      model_status();
    end
  endtask

  task automatic cycle(input bit iv, input bit ib, input bit ordy, input bit clr);
    InValid  = iv;
    InBit    = ib;
    OutReady = ordy;
    Clear    = clr;
    @(negedge CLOCK);
    chk("in_ready", InReady, m_ready);
    chk("out_valid", OutValid, m_valid);
    chk("overflow", Overflow, m_ovf);
    @(posedge CLOCK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    InValid  = 1'b0;
    OutReady = 1'b0;
    Clear    = 1'b0;
    Reset    = 1'b1;
    #1;
    chk("rst_out_valid", OutValid, 0);
    chk("rst_in_ready", InReady, 1);
    chk("rst_overflow", Overflow, 0);
    model_flush();
    @(negedge CLOCK);
    @(posedge CLOCK);
    #1;
    Reset = 1'b0;
  endtask

  // Monitor: OutBit must match the scoreboard head whenever valid; pop on acceptance.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (!Reset && OutValid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: OutValid=1 with no complete block expected at %0t", $time);
        end else begin
          chk("out_bit", OutBit, exp_q[0]);
          if (OutReady) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit [7:0] blk;
    Reset    = 1'b1;
    Clear    = 1'b0;
    InValid  = 1'b0;
    InBit    = 1'b0;
    OutReady = 1'b0;
    model_flush();
    #1;
    chk("init_in_ready", InReady, 1);
    chk("init_out_valid", OutValid, 0);
    chk("init_overflow", Overflow, 0);
    @(posedge CLOCK);
    #1;
    Reset = 1'b0;

    // Single block: written 1,1,0,1,0,0,1,0 must read back 0,1,0,0,1,0,1,1.
    blk = 8'b0100_1011;  // bit i = i-th written bit
    for (int i = 0; i < 8; i++) cycle(1'b1, blk[i], 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Streaming: 64 bits, each block is the binary counter value of its index.
    for (int i = 0; i < 64; i++) cycle(1'b1, bit'(((i / 8) >> (i % 8)) & 1), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: 17 writes with no reader, then drain both blocks.
    for (int i = 0; i < 17; i++) cycle(1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear after 12 writes, then a fresh block.
    for (int i = 0; i < 12; i++) cycle(1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset after 3 of 8 bits have been read, then a new block.
    for (int i = 0; i < 8; i++) cycle(1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Stall for 5 cycles in the middle of a block.
    for (int i = 0; i < 8; i++) cycle(1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 4) < 3), bit'($urandom_range(0, 249) == 0));
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
